// File: rtl/t07_tft_pkg.sv
// Shared types and constants for the TFT serializer scheduler.
package t07_tft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2,
    GAP   = 2'd3
  } tft_sched_state_t;

  localparam int SER_FRAME_BITS   = 64;
  localparam int SER_BUSY_LATENCY = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/t07_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr+1 with wrap.
module t07_rr_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  input  logic                     enable,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_idx,
  output logic                     grant_any
);

  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (enable && !grant_any && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = $clog2(N_REQ)'(idx);
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/t07_tft_scheduler.sv
// Shares the SPI TFT serializer between requesters: one 64-bit transfer per grant,
// enforced chip-select gap, start/transfer timeouts with a sticky error flag.
//   state | meaning
//   IDLE  | waiting for any req_valid; grant issued here only
//   START | ser_wi high, waiting for ser_busy to rise
//   XFER  | serializer busy, waiting for ser_busy to fall
//   GAP   | ser_wi low for GAP_CYCLES before the next grant
module t07_tft_scheduler
  import t07_tft_pkg::*;
#(
  parameter int N_REQ         = 2,
  parameter int GAP_CYCLES    = 2,
  parameter int START_TIMEOUT = 4,
  parameter int XFER_TIMEOUT  = 80
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [32*N_REQ-1:0]  req_addr,
  input  logic [32*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     req_done,
  output logic                 ser_wi,
  output logic [31:0]          ser_addr,
  output logic [31:0]          ser_data,
  input  logic                 ser_busy,
  output logic                 sched_busy,
  output logic                 timeout_err,
  input  logic                 err_clr
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(max3(START_TIMEOUT, XFER_TIMEOUT, GAP_CYCLES) + 1);

  tft_sched_state_t state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [PW-1:0]    ptr;
  logic             wi_nxt;
  logic [N_REQ-1:0] done_nxt;
  logic             tmo;
  logic             load;
  logic             arb_en;
  logic [N_REQ-1:0] grant;
  logic [PW-1:0]    grant_idx;
  logic             grant_any;

  // No grant during a reset cycle: the latch it would imply is discarded anyway.
  assign arb_en = (state == IDLE) && !rst;

  t07_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .enable    (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign req_ready  = grant;
  assign sched_busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wi_nxt    = ser_wi;
    done_nxt  = '0;
    tmo       = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (grant_any) begin
          load      = 1'b1;
          wi_nxt    = 1'b1;
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end
      START: begin
        if (ser_busy) begin
          state_nxt = XFER;
          cnt_nxt   = '0;
        end else if (cnt == CW'(START_TIMEOUT - 1)) begin
          tmo = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      XFER: begin
        if (!ser_busy) begin
          wi_nxt        = 1'b0;
          done_nxt[ptr] = 1'b1;
          state_nxt     = GAP;
          cnt_nxt       = '0;
        end else if (cnt == CW'(XFER_TIMEOUT - 1)) begin
          tmo = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      GAP: begin
        if (cnt == CW'(GAP_CYCLES - 1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
    endcase
    // Both stall cases abort the same way: release the serializer and report done.
    if (tmo) begin
      wi_nxt        = 1'b0;
      done_nxt      = '0;
      done_nxt[ptr] = 1'b1;
      state_nxt     = GAP;
      cnt_nxt       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      ptr         <= PW'(N_REQ - 1);
      ser_wi      <= 1'b0;
      ser_addr    <= '0;
      ser_data    <= '0;
      req_done    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      ser_wi   <= wi_nxt;
      req_done <= done_nxt;
      if (tmo)
        timeout_err <= 1'b1;
      else if (err_clr)
        timeout_err <= 1'b0;
      if (load) begin
        ptr      <= grant_idx;
        ser_addr <= req_addr[32*grant_idx +: 32];
        ser_data <= req_data[32*grant_idx +: 32];
      end
    end
  end

endmodule

// File: tb/tb_t07_tft_scheduler.sv
// Bench for t07_tft_scheduler: transaction-timeline model plus per-cycle compare.
module tb_t07_tft_scheduler;

  localparam int N        = 2;
  localparam int GAP      = 2;
  localparam int ST_TO    = 4;
  localparam int XF_TO    = 80;
  localparam int BUSY_LAT = 2;
  localparam int BUSY_HI  = 65;
  localparam int M_NOM    = 0;
  localparam int M_NEVER  = 1;
  localparam int M_STUCK  = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           err_clr = 1'b0;
  logic           ser_busy = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [32*N-1:0] req_addr = '0;
  logic [32*N-1:0] req_data = '0;
  logic [N-1:0]   req_ready, req_done;
  logic           ser_wi, sched_busy, timeout_err;
  logic [31:0]    ser_addr, ser_data;

  t07_tft_scheduler #(
    .N_REQ(N), .GAP_CYCLES(GAP), .START_TIMEOUT(ST_TO), .XFER_TIMEOUT(XF_TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .req_done(req_done),
    .ser_wi(ser_wi), .ser_addr(ser_addr), .ser_data(ser_data),
    .ser_busy(ser_busy), .sched_busy(sched_busy),
    .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;
  int want[N], served[N];
  logic [31:0] a_base[N], d_base[N];
  int ser_mode = M_NOM;

  // model: one transaction timeline (grant cycle, cycle ser_wi falls)
  bit          m_act = 1'b0, m_to = 1'b0, m_err = 1'b0;
  int          m_g = 0, m_grant = 0, m_fall = 0, m_ptr = N - 1;
  logic [31:0] m_addr = '0, m_data = '0;
  int          glog[$], gcyc[$];
  int          wi_run = 0, last_wi_run = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  // cycles from grant to the first cycle with ser_wi low again
  function automatic int span(input int mode);
    if (mode == M_NEVER) return 1 + ST_TO;
    if (mode == M_STUCK) return 2 + XF_TO;
    if (BUSY_HI <= XF_TO) return 1 + BUSY_LAT + BUSY_HI + 1;
    return 1 + BUSY_LAT + 1 + XF_TO;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (want[i] > served[i]);
      req_addr[32*i +: 32] = req_valid[i] ? a_base[i] + 32'(served[i] * 16) : 32'hDEAD_BEEF;
      req_data[32*i +: 32] = req_valid[i] ? d_base[i] + 32'(served[i]) : 32'hDEAD_BEEF;
    end
    case (ser_mode)
      M_STUCK: ser_busy = 1'b1;
      M_NEVER: ser_busy = 1'b0;
      default: ser_busy = m_act && (cyc >= m_grant + 1 + BUSY_LAT) &&
                          (cyc < m_grant + 1 + BUSY_LAT + BUSY_HI);
    endcase
  endtask

  task automatic step(input bit r, input bit ec);
    int g, idx;
    logic [N-1:0] rdy_e, done_e;
    @(posedge clk);
    #1;
    rst = r;
    err_clr = ec;
    drive();
    @(negedge clk);
    g = -1;
    idx = 0;
    if (!rst && (!m_act || cyc >= m_fall + GAP))
      for (int k = 1; k <= N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    rdy_e = '0;
    if (g >= 0) rdy_e[g] = 1'b1;
    done_e = '0;
    if (m_act && cyc == m_fall) done_e[m_g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(rdy_e));
    chk("req_done", 32'(req_done), 32'(done_e));
    chk("ser_wi", 32'(ser_wi), 32'(m_act && cyc > m_grant && cyc < m_fall));
    chk("sched_busy", 32'(sched_busy), 32'(m_act && cyc > m_grant && cyc < m_fall + GAP));
    chk("timeout_err", 32'(timeout_err), 32'(m_err));
    chk("ser_addr", ser_addr, m_addr);
    chk("ser_data", ser_data, m_data);
    if (ser_wi) wi_run++;
    else begin
      if (wi_run > 0) last_wi_run = wi_run;
      wi_run = 0;
    end
    if (rst) begin
      m_act = 1'b0; m_ptr = N - 1; m_err = 1'b0; m_addr = '0; m_data = '0;
    end else begin
      if (m_act && m_to && cyc + 1 == m_fall) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
      if (g >= 0) begin
        m_act = 1'b1; m_g = g; m_grant = cyc; m_ptr = g;
        m_fall = cyc + span(ser_mode);
        m_to = (ser_mode != M_NOM) || (BUSY_HI > XF_TO);
        m_addr = req_addr[32*g +: 32];
        m_data = req_data[32*g +: 32];
        served[g]++;
        glog.push_back(g);
        gcyc.push_back(cyc);
      end
    end
    cyc++;
  endtask

  int exp_ord[4] = '{0, 1, 0, 1};

  initial begin
    for (int i = 0; i < N; i++) begin want[i] = 0; served[i] = 0; end
    a_base[0] = 32'h8000_0010; d_base[0] = 32'h1234_5678;
    a_base[1] = 32'h8000_0100; d_base[1] = 32'hA5A5_0000;

    repeat (3) step(1'b1, 1'b0);
    chk("rst_sched_busy", 32'(sched_busy), 32'd0);
    chk("rst_ser_wi", 32'(ser_wi), 32'd0);

    // single request, nominal serializer
    want[0] = 1;
    step(1'b0, 1'b0);
    chk("single_grant_cnt", 32'(glog.size()), 32'd1);
    step(1'b0, 1'b0);
    chk("single_addr", ser_addr, 32'h8000_0010);
    chk("single_data", ser_data, 32'h1234_5678);
    repeat (75) step(1'b0, 1'b0);
    chk("single_wi_len", 32'(last_wi_run), 32'd68);
    chk("single_err", 32'(timeout_err), 32'd0);

    // contention from reset: 0,1,0,1
    step(1'b1, 1'b0);
    glog.delete(); gcyc.delete();
    want[0] += 2; want[1] += 2;
    repeat (300) step(1'b0, 1'b0);
    chk("cont_grants", 32'(glog.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < glog.size()) chk("cont_order", 32'(glog[i]), 32'(exp_ord[i]));
    chk("cont_wi_len", 32'(last_wi_run), 32'd68);

    // start timeout: busy never rises
    ser_mode = M_NEVER;
    glog.delete(); gcyc.delete();
    want[0]++; want[1]++;
    repeat (20) step(1'b0, 1'b0);
    chk("sto_grants", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) begin
      chk("sto_first", 32'(glog[0]), 32'd0);
      chk("sto_second", 32'(glog[1]), 32'd1);
      chk("sto_spacing", 32'(gcyc[1] - gcyc[0]), 32'd7);
    end
    chk("sto_wi_len", 32'(last_wi_run), 32'd4);
    chk("sto_err", 32'(timeout_err), 32'd1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("sto_err_clr", 32'(timeout_err), 32'd0);

    // transfer timeout: busy stuck high
    ser_mode = M_STUCK;
    glog.delete(); gcyc.delete();
    want[0]++;
    repeat (90) step(1'b0, 1'b0);
    chk("xto_grant", 32'(glog.size()), 32'd1);
    chk("xto_wi_len", 32'(last_wi_run), 32'd81);
    chk("xto_err", 32'(timeout_err), 32'd1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("xto_err_clr", 32'(timeout_err), 32'd0);
    want[1]++;
    step(1'b0, 1'b1);
    for (int n = 0; n < 200 && cyc < m_fall; n++) step(1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b0);
    chk("xto_set_beats_clr", 32'(timeout_err), 32'd1);

    // reset in the 30th busy cycle of a transfer
    ser_mode = M_NOM;
    step(1'b0, 1'b1);
    glog.delete(); gcyc.delete();
    want[0]++;
    step(1'b0, 1'b0);
    repeat (31) step(1'b0, 1'b0);
    chk("mid_wi_before", 32'(ser_wi), 32'd1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("mid_wi_after", 32'(ser_wi), 32'd0);
    chk("mid_busy_after", 32'(sched_busy), 32'd0);
    chk("mid_no_done", 32'(req_done), 32'd0);
    want[1]++;
    step(1'b0, 1'b0);
    chk("mid_regrant", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) chk("mid_regrant_idx", 32'(glog[1]), 32'd1);
    chk("mid_ready1", 32'(req_ready), 32'b10);
    repeat (80) step(1'b0, 1'b0);
    chk("mid_final_wi_len", 32'(last_wi_run), 32'd68);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
